// File: rtl/sync_fifo_fwft_if.sv
// Handshake bundle between a same-clock producer/consumer pair and sync_fifo_fwft.
// The FIFO uses the slave view; the environment driving writes and reads uses the master view.
interface sync_fifo_fwft_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 5
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  afull;
    logic                  aempty;
    logic [CNT_WIDTH-1:0]  data_cnt;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, afull, aempty, data_cnt, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, afull, aempty, data_cnt, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable standard or first-word-fall-through read,
// exact occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_AFULL  = FIFO_DEPTH - 2,
    parameter int FIFO_AEMPTY = 2,
    parameter int FWFT_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_fwft_if.slave  fifo_if
);
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0]  PTR_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  full_q, empty_q, afull_q, aempty_q;
    logic                  overflow_q, underflow_q;
    logic                  wr_acc, rd_acc, head_from_wr;

    assign wr_acc     = fifo_if.wr_en & ~full_q;
    assign rd_acc     = fifo_if.rd_en & ~empty_q;
    assign rd_ptr_nxt = rd_ptr_q + PTR_ONE;

    // In FWFT mode the incoming word becomes the head when nothing else is left to present.
    assign head_from_wr = wr_acc && ((cnt_q == '0) || (rd_acc && (cnt_q == CNT_ONE)));

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_nxt : rd_ptr_q;

        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (FWFT_MODE != 0) begin
            rd_valid_d = (cnt_d != '0);
            if (head_from_wr)
                rd_data_d = fifo_if.wr_data;
            else if (rd_acc && (cnt_d != '0))
                rd_data_d = mem_q[rd_ptr_nxt[ADDR_WIDTH-1:0]];
        end else begin
            rd_valid_d = rd_acc;
            if (rd_acc)
                rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= fifo_if.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            full_q      <= (cnt_d == CNT_WIDTH'(FIFO_DEPTH));
            empty_q     <= (cnt_d == '0);
            afull_q     <= (cnt_d >= CNT_WIDTH'(FIFO_AFULL));
            aempty_q    <= (cnt_d <= CNT_WIDTH'(FIFO_AEMPTY));
            overflow_q  <= overflow_q  | (fifo_if.wr_en & full_q);
            underflow_q <= underflow_q | (fifo_if.rd_en & empty_q);
        end
    end

    assign fifo_if.rd_data   = rd_data_q;
    assign fifo_if.rd_valid  = rd_valid_q;
    assign fifo_if.full      = full_q;
    assign fifo_if.empty     = empty_q;
    assign fifo_if.afull     = afull_q;
    assign fifo_if.aempty    = aempty_q;
    assign fifo_if.data_cnt  = cnt_q;
    assign fifo_if.overflow  = overflow_q;
    assign fifo_if.underflow = underflow_q;
endmodule
